// File: rtl/ac97_pkg.sv
// Shared AC97 register map, command constants and sequencer state type.
package ac97_pkg;

    typedef enum logic [1:0] {IDLE, INIT, RUN} seq_state_e;

    localparam logic [7:0]  ADDR_HP_VOL   = 8'h04;
    localparam logic [7:0]  ADDR_PCM_VOL  = 8'h18;
    localparam logic [7:0]  ADDR_REC_SEL  = 8'h1A;
    localparam logic [7:0]  ADDR_REC_GAIN = 8'h1C;
    localparam logic [7:0]  ADDR_MIC_VOL  = 8'h0E;
    localparam logic [7:0]  ADDR_BEEP_VOL = 8'h0A;
    localparam logic [7:0]  ADDR_GP       = 8'h20;

    // Read of register 0 (vendor ID); harmless filler when nothing is pending.
    localparam logic [23:0] CMD_IDLE      = 24'h80_0000;

    localparam logic [15:0] REC_GAIN_DATA = 16'h0F0F;
    localparam logic [15:0] MIC_DATA      = 16'h8008;
    localparam logic [15:0] MIC_DATA_BST  = 16'h8048;
    localparam logic [15:0] BEEP_DATA     = 16'h0000;
    localparam logic [15:0] GP_DATA       = 16'h8000;

    function automatic logic [15:0] stereo_att(input logic [4:0] att);
        return {3'b000, att, 3'b000, att};
    endfunction

    function automatic logic [15:0] rec_select(input logic [2:0] src);
        return {5'b00000, src, 5'b00000, src};
    endfunction

endpackage

// File: rtl/ac97_vol_atten.sv
// Converts a VOL_W-bit level (all-ones = loudest) into a 5-bit AC97 attenuation.
module ac97_vol_atten #(
    parameter int unsigned VOL_W = 5
) (
    input  logic [VOL_W-1:0] level,
    output logic [4:0]       att
);

    localparam logic [4:0]  MAX_LEVEL = 5'((1 << VOL_W) - 1);
    localparam int unsigned SHIFT     = 5 - VOL_W;

    logic [4:0] diff;

    assign diff = MAX_LEVEL - 5'(level);
    // Narrow levels are scaled up so the full 5-bit attenuation range is spanned.
    assign att  = diff << SHIFT;

endmodule

// File: rtl/ac97_cmd_seq.sv
// AC97 codec command sequencer: fixed init table, then host writes and level-change updates.
module ac97_cmd_seq
    import ac97_pkg::*;
#(
    parameter int unsigned VOL_W = 5,
    parameter int unsigned HOLD  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ready,
    input  logic [VOL_W-1:0] volume,
    input  logic [VOL_W-1:0] pcm_volume,
    input  logic [2:0]       source,
    input  logic             mic_boost,
    input  logic             host_req,
    input  logic [6:0]       host_addr,
    input  logic [15:0]      host_data,
    output logic             host_ack,
    output logic [7:0]       command_address,
    output logic [15:0]      command_data,
    output logic             command_valid,
    output logic             init_done
);

    seq_state_e       state_q, state_d;
    logic [3:0]       slot_cnt_q, slot_cnt_d;
    logic [2:0]       entry_q, entry_d;
    logic [23:0]      cmd_q, cmd_d;
    logic             valid_q, valid_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic [VOL_W-1:0] vol_sh_q, vol_sh_d;
    logic [VOL_W-1:0] pcm_sh_q, pcm_sh_d;
    logic [2:0]       src_sh_q, src_sh_d;
    logic             mic_sh_q, mic_sh_d;

    logic             boundary;
    logic             load_init;
    logic             load_run;
    logic [2:0]       init_idx;
    logic [4:0]       hp_att;
    logic [4:0]       pcm_att;

    ac97_vol_atten #(.VOL_W(VOL_W)) u_hp_atten (
        .level (volume),
        .att   (hp_att)
    );

    ac97_vol_atten #(.VOL_W(VOL_W)) u_pcm_atten (
        .level (pcm_volume),
        .att   (pcm_att)
    );

    assign boundary = ready && (slot_cnt_q == 4'(HOLD - 1));

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        entry_d    = entry_q;
        cmd_d      = cmd_q;
        valid_d    = valid_q;
        ack_d      = 1'b0;
        done_d     = done_q;
        vol_sh_d   = vol_sh_q;
        pcm_sh_d   = pcm_sh_q;
        src_sh_d   = src_sh_q;
        mic_sh_d   = mic_sh_q;
        load_init  = 1'b0;
        load_run   = 1'b0;
        init_idx   = entry_q + 3'd1;

        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d    = INIT;
                    slot_cnt_d = '0;
                    entry_d    = '0;
                    init_idx   = '0;
                    load_init  = 1'b1;
                end
            end
            INIT, RUN: begin
                if (boundary) begin
                    slot_cnt_d = '0;
                    if (state_q == RUN) begin
                        load_run = 1'b1;
                    end else if (entry_q == 3'd7) begin
                        state_d  = RUN;
                        done_d   = 1'b1;
                        load_run = 1'b1;
                    end else begin
                        entry_d   = entry_q + 3'd1;
                        load_init = 1'b1;
                    end
                end else if (ready) begin
                    slot_cnt_d = slot_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shadows capture the value actually issued, so later changes re-issue.
        if (load_init) begin
            valid_d = 1'b1;
            unique case (init_idx)
                3'd0: cmd_d = CMD_IDLE;
                3'd1: begin
                    cmd_d    = {ADDR_HP_VOL, stereo_att(hp_att)};
                    vol_sh_d = volume;
                end
                3'd2: begin
                    cmd_d    = {ADDR_PCM_VOL, stereo_att(pcm_att)};
                    pcm_sh_d = pcm_volume;
                end
                3'd3: begin
                    cmd_d    = {ADDR_REC_SEL, rec_select(source)};
                    src_sh_d = source;
                end
                3'd4: cmd_d = {ADDR_REC_GAIN, REC_GAIN_DATA};
                3'd5: begin
                    cmd_d    = {ADDR_MIC_VOL, mic_boost ? MIC_DATA_BST : MIC_DATA};
                    mic_sh_d = mic_boost;
                end
                3'd6: cmd_d = {ADDR_BEEP_VOL, BEEP_DATA};
                3'd7: cmd_d = {ADDR_GP, GP_DATA};
                default: cmd_d = CMD_IDLE;
            endcase
        end

        if (load_run) begin
            if (host_req) begin
                cmd_d = {1'b0, host_addr, host_data};
                ack_d = 1'b1;
            end else if (volume != vol_sh_q) begin
                cmd_d    = {ADDR_HP_VOL, stereo_att(hp_att)};
                vol_sh_d = volume;
            end else if (pcm_volume != pcm_sh_q) begin
                cmd_d    = {ADDR_PCM_VOL, stereo_att(pcm_att)};
                pcm_sh_d = pcm_volume;
            end else if (source != src_sh_q) begin
                cmd_d    = {ADDR_REC_SEL, rec_select(source)};
                src_sh_d = source;
            end else if (mic_boost != mic_sh_q) begin
                cmd_d    = {ADDR_MIC_VOL, mic_boost ? MIC_DATA_BST : MIC_DATA};
                mic_sh_d = mic_boost;
            end else begin
                cmd_d = CMD_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            slot_cnt_q <= '0;
            entry_q    <= '0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            vol_sh_q   <= '0;
            pcm_sh_q   <= '0;
            src_sh_q   <= '0;
            mic_sh_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            entry_q    <= entry_d;
            cmd_q      <= cmd_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            vol_sh_q   <= vol_sh_d;
            pcm_sh_q   <= pcm_sh_d;
            src_sh_q   <= src_sh_d;
            mic_sh_q   <= mic_sh_d;
        end
    end

    assign command_address = cmd_q[23:16];
    assign command_data    = cmd_q[15:0];
    assign command_valid   = valid_q;
    assign host_ack        = ack_q;
    assign init_done       = done_q;

endmodule

// File: tb/tb_ac97_cmd_seq.sv
// Randomized bench for ac97_cmd_seq against a slot-arithmetic reference model.
module tb_ac97_cmd_seq;

    localparam int VW   = 5;
    localparam int HOLD = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ready = 1'b0;
    logic [VW-1:0] volume = '0;
    logic [VW-1:0] pcm_volume = '0;
    logic [2:0]    source = '0;
    logic          mic_boost = 1'b0;
    logic          host_req = 1'b0;
    logic [6:0]    host_addr = '0;
    logic [15:0]   host_data = '0;
    logic          host_ack;
    logic [7:0]    command_address;
    logic [15:0]   command_data;
    logic          command_valid;
    logic          init_done;

    logic [2:0]    vol3 = '0;
    logic [2:0]    pcm3 = '0;
    logic          host_ack3;
    logic [7:0]    cmd_addr3;
    logic [15:0]   cmd_data3;
    logic          cmd_valid3;
    logic          init_done3;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int            m_pulses = 0;
    logic [23:0]   m_cmd = '0;
    logic          m_valid = 1'b0;
    logic          m_ack = 1'b0;
    logic          m_done = 1'b0;
    logic          m_load = 1'b0;
    logic [VW-1:0] m_sh_vol = '0;
    logic [VW-1:0] m_sh_pcm = '0;
    logic [2:0]    m_sh_src = '0;
    logic          m_sh_mic = 1'b0;

    logic [26:0]   dut_obs;

    always #5 clock = ~clock;

    ac97_cmd_seq #(.VOL_W(VW), .HOLD(HOLD)) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ready           (ready),
        .volume          (volume),
        .pcm_volume      (pcm_volume),
        .source          (source),
        .mic_boost       (mic_boost),
        .host_req        (host_req),
        .host_addr       (host_addr),
        .host_data       (host_data),
        .host_ack        (host_ack),
        .command_address (command_address),
        .command_data    (command_data),
        .command_valid   (command_valid),
        .init_done       (init_done)
    );

    ac97_cmd_seq #(.VOL_W(3), .HOLD(1)) u_dut3 (
        .clock           (clock),
        .reset_n         (reset_n),
        .ready           (ready),
        .volume          (vol3),
        .pcm_volume      (pcm3),
        .source          (source),
        .mic_boost       (mic_boost),
        .host_req        (host_req),
        .host_addr       (host_addr),
        .host_data       (host_data),
        .host_ack        (host_ack3),
        .command_address (cmd_addr3),
        .command_data    (cmd_data3),
        .command_valid   (cmd_valid3),
        .init_done       (init_done3)
    );

    assign dut_obs = {command_address, command_data, command_valid, host_ack, init_done};

    function automatic logic [26:0] m_obs();
        return {m_cmd, m_valid, m_ack, m_done};
    endfunction

    function automatic logic [4:0] f_att(input int vw, input int level);
        return 5'((((1 << vw) - 1) - level) << (5 - vw));
    endfunction

    function automatic logic [15:0] f_stereo(input logic [4:0] a);
        return {3'b000, a, 3'b000, a};
    endfunction

    function automatic logic [23:0] f_mic(input logic boost);
        return boost ? 24'h0E8048 : 24'h0E8008;
    endfunction

    // Advance one clock, update the model from the inputs seen at that edge.
    task automatic tick();
        int slot;
        @(posedge clock);
        m_ack  = 1'b0;
        m_load = 1'b0;
        if (!reset_n) begin
            m_pulses = 0;
            m_cmd    = '0;
            m_valid  = 1'b0;
            m_done   = 1'b0;
            m_sh_vol = '0;
            m_sh_pcm = '0;
            m_sh_src = '0;
            m_sh_mic = 1'b0;
        end else if (ready) begin
            m_pulses++;
            if ((m_pulses - 1) % HOLD == 0) begin
                slot    = (m_pulses - 1) / HOLD;
                m_load  = 1'b1;
                m_valid = 1'b1;
                if (slot < 8) begin
                    case (slot)
                        0: m_cmd = 24'h800000;
                        1: begin m_cmd = {8'h04, f_stereo(f_att(VW, int'(volume)))}; m_sh_vol = volume; end
                        2: begin m_cmd = {8'h18, f_stereo(f_att(VW, int'(pcm_volume)))}; m_sh_pcm = pcm_volume; end
                        3: begin m_cmd = {8'h1A, 5'b0, source, 5'b0, source}; m_sh_src = source; end
                        4: m_cmd = 24'h1C0F0F;
                        5: begin m_cmd = f_mic(mic_boost); m_sh_mic = mic_boost; end
                        6: m_cmd = 24'h0A0000;
                        default: m_cmd = 24'h208000;
                    endcase
                end else begin
                    m_done = 1'b1;
                    if (host_req) begin
                        m_cmd = {1'b0, host_addr, host_data};
                        m_ack = 1'b1;
                    end else if (volume != m_sh_vol) begin
                        m_cmd = {8'h04, f_stereo(f_att(VW, int'(volume)))}; m_sh_vol = volume;
                    end else if (pcm_volume != m_sh_pcm) begin
                        m_cmd = {8'h18, f_stereo(f_att(VW, int'(pcm_volume)))}; m_sh_pcm = pcm_volume;
                    end else if (source != m_sh_src) begin
                        m_cmd = {8'h1A, 5'b0, source, 5'b0, source}; m_sh_src = source;
                    end else if (mic_boost != m_sh_mic) begin
                        m_cmd = f_mic(mic_boost); m_sh_mic = mic_boost;
                    end else begin
                        m_cmd = 24'h800000;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ready   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if (dut_obs !== 27'h0) begin
                n_err++;
                $display("FAIL test_reset cyc %0d: got %h want %h", c, dut_obs, 27'h0);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_init();
        int gap = 0;
        volume     = 5'd31;
        source     = 3'd0;
        pcm_volume = VW'($urandom);
        mic_boost  = 1'($urandom);
        host_req   = 1'b0;
        apply_reset();
        for (int c = 0; c < 200 && m_pulses < 18; c++) begin
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            tick();
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_init cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
            if (ready && (m_pulses == 1 || m_pulses == 3 || m_pulses == 15 || m_pulses == 17)) begin
                n_vec++;
                if (m_pulses == 1 && {command_address, command_data} !== 24'h800000) begin
                    n_err++;
                    $display("FAIL init_ready1: got %h want 800000", {command_address, command_data});
                end
                if (m_pulses == 3 && {command_address, command_data} !== 24'h040000) begin
                    n_err++;
                    $display("FAIL init_ready3: got %h want 040000", {command_address, command_data});
                end
                if (m_pulses == 15 && init_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL init_done_early: got %b want 0", init_done);
                end
                if (m_pulses == 17 && init_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL init_done_ready17: got %b want 1", init_done);
                end
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_vol_change();
        logic [23:0] seen[$];
        int gap = 1;
        volume = 5'd10;
        for (int c = 0; c < 60; c++) begin
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            tick();
            if (m_load) seen.push_back({command_address, command_data});
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_vol_change cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
        end
        ready = 1'b0;
        n_vec++;
        if (seen.size() < 3 || seen[0] !== 24'h041515 || seen[1] !== 24'h800000
            || seen[2] !== 24'h800000) begin
            n_err++;
            $display("FAIL vol_change_slots: got %p want 041515,800000,800000", seen);
        end
    endtask

    task automatic test_host_src();
        logic [23:0] seen[$];
        int gap  = 1;
        int acks = 0;
        host_addr = 7'h02;
        host_data = 16'h8000;
        host_req  = 1'b1;
        source    = 3'd4;
        for (int c = 0; c < 60; c++) begin
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            tick();
            if (m_load) seen.push_back({command_address, command_data});
            if (host_ack === 1'b1) acks++;
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_host_src cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
            if (m_ack) host_req = 1'b0;
        end
        ready    = 1'b0;
        host_req = 1'b0;
        n_vec++;
        if (seen.size() < 3 || seen[0] !== 24'h028000 || seen[1] !== 24'h1A0404
            || seen[2] !== 24'h800000 || acks != 1) begin
            n_err++;
            $display("FAIL host_src_slots: got %p acks %0d want 028000,1A0404,800000 acks 1",
                     seen, acks);
        end
    endtask

    task automatic test_random();
        int gap = 0;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) volume = VW'($urandom);
            if ($urandom_range(0, 19) == 0) pcm_volume = VW'($urandom);
            if ($urandom_range(0, 29) == 0) source = 3'($urandom);
            if ($urandom_range(0, 29) == 0) mic_boost = ~mic_boost;
            if (!host_req && $urandom_range(0, 24) == 0) begin
                host_req  = 1'b1;
                host_addr = 7'($urandom);
                host_data = 16'($urandom);
            end
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            tick();
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_random cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
            if (m_ack) host_req = 1'b0;
        end
        ready    = 1'b0;
        host_req = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        int gap = 0;
        host_req = 1'b0;
        apply_reset();
        for (int c = 0; c < 100 && m_pulses < 9; c++) begin
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            tick();
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_reset_mid_init cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
        end
        ready = 1'b0;
        tick();
        n_vec++;
        if ({command_address, command_data} !== 24'h1C0F0F) begin
            n_err++;
            $display("FAIL entry4_loaded: got %h want 1C0F0F", {command_address, command_data});
        end
        reset_n = 1'b0;
        tick();
        n_vec++;
        if (dut_obs !== 27'h0) begin
            n_err++;
            $display("FAIL reset_mid_init_zero: got %h want %h", dut_obs, 27'h0);
        end
        reset_n = 1'b1;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_vec++;
        if (dut_obs !== {24'h800000, 3'b100}) begin
            n_err++;
            $display("FAIL reset_mid_init_restart: got %h want %h", dut_obs, {24'h800000, 3'b100});
        end
    endtask

    task automatic test_host_in_init();
        int gap = 0;
        logic [23:0] exp_host;
        apply_reset();
        host_addr = 7'($urandom);
        host_data = 16'($urandom);
        host_req  = 1'b1;
        exp_host  = {1'b0, host_addr, host_data};
        for (int c = 0; c < 200 && m_pulses < 17; c++) begin
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            tick();
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_host_in_init cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
            if (m_pulses < 17 && host_ack !== 1'b0) begin
                n_err++;
                $display("FAIL host_ack_in_init: got %b want 0", host_ack);
            end
        end
        n_vec++;
        if (m_pulses != 17 || {command_address, command_data} !== exp_host || host_ack !== 1'b1) begin
            n_err++;
            $display("FAIL host_first_run_slot: got %h ack %b want %h ack 1",
                     {command_address, command_data}, host_ack, exp_host);
        end
        host_req = 1'b0;
        ready    = 1'b0;
        tick();
    endtask

    task automatic test_vol_w3();
        int pulses = 0;
        int gap    = 0;
        logic [23:0] exp3;
        vol3 = 3'd2;
        pcm3 = 3'($urandom);
        exp3 = {8'h04, f_stereo(f_att(3, 2))};
        apply_reset();
        for (int c = 0; c < 20 && pulses < 2; c++) begin
            ready = (gap == 0);
            gap   = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            if (ready) pulses++;
            tick();
            n_vec++;
            if (dut_obs !== m_obs()) begin
                n_err++;
                $display("FAIL test_vol_w3_main cyc %0d: got %h want %h", c, dut_obs, m_obs());
            end
        end
        ready = 1'b0;
        n_vec++;
        if ({cmd_addr3, cmd_data3} !== exp3 || cmd_valid3 !== 1'b1) begin
            n_err++;
            $display("FAIL vol_w3_headphone: got %h valid %b want %h valid 1",
                     {cmd_addr3, cmd_data3}, cmd_valid3, exp3);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_vol_change();
        test_host_src();
        test_random();
        test_reset_mid_init();
        test_host_in_init();
        test_vol_w3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ac97_cmd_seq.md
AC97_CMD_SEQ -- requirements
Module: ac97_cmd_seq

Interface
REQ-001 SHALL have parameter VOL_W, default 5, volume input width, legal range 1..5.
REQ-002 SHALL have parameter HOLD, default 2, number of ready pulses each command is held, legal range 1..15.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on posedge clock.
REQ-004 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port ready, input, 1, one-cycle pulse per AC97 frame.
REQ-006 SHALL have ports volume and pcm_volume, input, VOL_W each, headphone and PCM level (all-ones = loudest).
REQ-007 SHALL have ports source (input, 3, record source) and mic_boost (input, 1, +20 dB mic gain enable).
REQ-008 SHALL have ports host_req (in, 1), host_addr (in, 7), host_data (in, 16), host_ack (out, 1): host register-write request.
REQ-009 SHALL have ports command_address (out, 8), command_data (out, 16), command_valid (out, 1), init_done (out, 1).

Function
REQ-010 SHALL implement the FSM states IDLE, INIT, RUN; reset enters IDLE.
REQ-011 SHALL leave IDLE on the first ready pulse, loading init entry 0 and setting command_valid=1 on that same edge.
REQ-012 SHALL hold each issued command for exactly HOLD ready pulses; the next command loads on the clock edge of the HOLD-th pulse (slot boundary).
REQ-013 SHALL issue 8 init entries in order: 80_0000; 04 headphone; 18 PCM; 1A {5'b0,source,5'b0,source}; 1C_0F0F; 0E (mic_boost ? 8048 : 8008); 0A_0000; 20_8000.
REQ-014 SHALL format headphone and PCM entries as {3'b0,att,3'b0,att}, where att = ((2^VOL_W-1) - level) << (5-VOL_W), 5 bits.
REQ-015 SHALL enter RUN and set init_done=1 at the slot boundary ending entry 7; init_done stays 1 until reset.
REQ-016 SHALL, in RUN, choose each new slot by priority: host_req, then headphone change, then PCM change, then source change, then mic_boost change, otherwise idle command 80_0000.
REQ-017 SHALL detect a change by comparing the live input with a shadow register of the value last issued; the shadow updates when the command is loaded.
REQ-018 SHALL, for a host slot, issue {1'b0,host_addr,host_data} and pulse host_ack high for exactly one clock on the load edge.
REQ-019 SHALL require host_req held until host_ack; host_req is ignored outside RUN, and host_ack is never asserted outside RUN.
REQ-020 SHALL, when several changes occur in one slot, serve them in successive slots in priority order, with none lost.
REQ-021 SHALL ignore input changes during INIT beyond the value sampled at each entry's load; the shadows then mismatch and cause re-issue in RUN.
REQ-022 SHALL keep command_valid=1 continuously from the first load until reset.
REQ-023 SHALL drive all command outputs from registers only, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, while reset_n=0 at a clock edge, set command_address=0, command_data=0, command_valid=0, host_ack=0, init_done=0, slot counter=0, state=IDLE and all shadows to 0.
REQ-025 SHALL, on reset mid-slot or mid-INIT, abandon the command and, after release, restart from IDLE at entry 0.

Structure
REQ-026 SHALL place AC97 register addresses, the idle/read-ID command 24'h80_0000 and the state enum in shared package ac97_pkg.
REQ-027 SHALL implement the level-to-attenuation conversion in sub-module ac97_vol_atten (parameter VOL_W), instantiated twice.

Verification
REQ-028 SHALL cover reset release with volume=31, source=0, HOLD=2: 80_0000 is loaded at ready 1; 04_0000 at ready 3; init_done=1 at ready 17; command_valid never drops.
REQ-029 SHALL cover a volume change to 10 in RUN: the next slot issues 04_1515; subsequent slots issue 80_0000.
REQ-030 SHALL cover host_req with addr 0x02 and data 0x8000 while source also changes to 4: the host slot issues 02_8000 with a 1-clock host_ack; the next slot issues 1A_0404.
REQ-031 SHALL cover VOL_W=3 with volume=2: the headphone entry issues 04_1414 (att=5<<2).
REQ-032 SHALL cover reset_n=0 asserted during INIT entry 4: outputs go to 0 on the next edge; after release, the sequence restarts at 80_0000.
REQ-033 SHALL cover a host_req asserted during INIT: no ack is given until RUN; the request is then served in the first RUN slot.
